// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the sprite/palette pipeline.
// Produces pixel coordinates, an active-video flag, syncs, a frame-start pulse
// and a wrapping frame counter. Every output is a register. The decodes are
// computed from the next position, so they line up with DrawX/DrawY with no skew.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   CW        = 10
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic          en,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          blank,
    output logic          hs,
    output logic          vs,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Inclusive bounds are used so that no bound needs a value equal to 2**CW.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_LAST = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] V_VIS_LAST = CW'(V_VISIBLE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CW-1:0] r_draw_x;
    logic [CW-1:0] r_draw_y;
    logic          r_blank;
    logic          r_hs;
    logic          r_vs;
    logic          r_frame_start;
    logic [7:0]    r_frame_count;

    logic [CW-1:0] w_x_n;
    logic [CW-1:0] w_y_n;
    logic          w_blank_n;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_fs_n;

    // Next raster position: X wraps at the line end, Y steps on X wrap and wraps at the frame end.
    always_comb begin
        w_x_n = r_draw_x;
        w_y_n = r_draw_y;
        if (r_draw_x == H_LAST) begin
            w_x_n = {CW{1'b0}};
            if (r_draw_y == V_LAST) begin
                w_y_n = {CW{1'b0}};
            end else begin
                w_y_n = r_draw_y + CW'(1);
            end
        end else begin
            w_x_n = r_draw_x + CW'(1);
            w_y_n = r_draw_y;
        end
    end

    // Decodes of the next position, registered together with it so they stay aligned.
    always_comb begin
        w_blank_n = (w_x_n <= H_VIS_LAST) && (w_y_n <= V_VIS_LAST);
        w_fs_n    = (w_x_n == {CW{1'b0}}) && (w_y_n == {CW{1'b0}});
        if ((w_x_n >= HS_FIRST) && (w_x_n <= HS_LAST)) begin
            w_hs_n = SYNC_POL;
        end else begin
            w_hs_n = ~SYNC_POL;
        end
        if ((w_y_n >= VS_FIRST) && (w_y_n <= VS_LAST)) begin
            w_vs_n = SYNC_POL;
        end else begin
            w_vs_n = ~SYNC_POL;
        end
    end

    // Raster state: advances on enabled edges, holds otherwise, async reset to the origin.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_draw_x      <= {CW{1'b0}};
            r_draw_y      <= {CW{1'b0}};
            r_blank       <= 1'b0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else if (en) begin
            r_draw_x      <= w_x_n;
            r_draw_y      <= w_y_n;
            r_blank       <= w_blank_n;
            r_hs          <= w_hs_n;
            r_vs          <= w_vs_n;
            r_frame_start <= w_fs_n;
            if (w_fs_n) begin
                r_frame_count <= r_frame_count + 8'd1;
            end else begin
                r_frame_count <= r_frame_count;
            end
        end else begin
            r_draw_x      <= r_draw_x;
            r_draw_y      <= r_draw_y;
            r_blank       <= r_blank;
            r_hs          <= r_hs;
            r_vs          <= r_vs;
            r_frame_start <= r_frame_start;
            r_frame_count <= r_frame_count;
        end
    end

    assign DrawX       = r_draw_x;
    assign DrawY       = r_draw_y;
    assign blank       = r_blank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
